// File: rtl/line_tx_if.sv
// Upstream pixel stream into line_tx: valid/ready handshake carrying one pixel per transfer.
interface line_tx_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/line_tx.sv
// Line transmitter: buffers upstream pixels in a small FIFO and emits fixed-length lines
// separated by horizontal blanking. Define LINE_TX_UFCNT_EN to add the uf_count port.
module line_tx #(
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 16,
  parameter int LENGTH       = 1920,
  parameter int HBLANK       = 16,
  parameter int FIFO_AW      = 4,
  parameter int START_THRESH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  line_tx_if.slave              s,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  output logic                  sol,
  output logic                  eol,
  output logic                  underflow
`ifdef LINE_TX_UFCNT_EN
  ,
  output logic [15:0]           uf_count
`endif
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]      DEPTH_C  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]      THRESH_C = (FIFO_AW + 1)'(START_THRESH);
  localparam logic [FIFO_AW:0]      CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0]    PTR_ONE  = FIFO_AW'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(LENGTH - 1);
  localparam logic [ADDR_WIDTH-1:0] COL_ONE  = ADDR_WIDTH'(1);
  localparam int BW = (HBLANK > 2) ? $clog2(HBLANK - 1) : 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'((HBLANK > 1) ? HBLANK - 2 : 0);
  localparam logic [BW-1:0] BLANK_ONE  = BW'(1);

  typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   col, col_next;
  logic [BW-1:0]           blank_cnt, blank_next;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [FIFO_AW-1:0]      wr_ptr, rd_ptr;
  logic [FIFO_AW:0]        count;
  logic                    push, pop, fill;

  logic [DATA_WIDTH-1:0]   data_next;
  logic                    valid_next, sol_next, eol_next;

  assign s.s_ready = (count != DEPTH_C);
  assign push      = s.s_valid && s.s_ready;
  // Pop decision uses the registered count, so a push into an empty FIFO cannot feed the same cycle.
  assign pop       = (state == ACTIVE) && (count != '0);
  assign fill      = (state == ACTIVE) && (count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s.s_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Outputs lag the state by one cycle, so the IDLE cycle after BLANK is itself a blank
  // output cycle; BLANK therefore lasts HBLANK-1 cycles and is skipped when HBLANK is 1.
  always_comb begin
    state_next = state;
    col_next   = col;
    blank_next = blank_cnt;
    valid_next = 1'b0;
    sol_next   = 1'b0;
    eol_next   = 1'b0;
    data_next  = '0;
    case (state)
      IDLE: begin
        col_next = '0;
        if (count >= THRESH_C) state_next = ACTIVE;
      end
      ACTIVE: begin
        valid_next = 1'b1;
        sol_next   = (col == '0);
        eol_next   = (col == LAST_COL);
        if (pop) data_next = mem[rd_ptr];
        if (col == LAST_COL) begin
          col_next   = '0;
          blank_next = '0;
          state_next = (HBLANK > 1) ? BLANK : IDLE;
        end else begin
          col_next = col + COL_ONE;
        end
      end
      BLANK: begin
        if (blank_cnt == BLANK_LAST) state_next = IDLE;
        else                         blank_next = blank_cnt + BLANK_ONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      col       <= '0;
      blank_cnt <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      sol       <= 1'b0;
      eol       <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_next;
      col       <= col_next;
      blank_cnt <= blank_next;
      data_out  <= data_next;
      out_valid <= valid_next;
      sol       <= sol_next;
      eol       <= eol_next;
      if (fill) underflow <= 1'b1;
    end
  end

`ifdef LINE_TX_UFCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                           uf_count <= '0;
    else if (fill && (uf_count != '1))    uf_count <= uf_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_line_tx.sv
// Directed bench for line_tx with LENGTH=8, HBLANK=2, FIFO_AW=3, START_THRESH=4.
module tb_line_tx;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  line_tx_if #(.DATA_WIDTH(DW)) bus ();

  logic [DW-1:0] data_out;
  logic          out_valid, sol, eol, underflow;
`ifdef LINE_TX_UFCNT_EN
  logic [15:0]   uf_count;
`endif

  line_tx #(
    .ADDR_WIDTH  (11),
    .DATA_WIDTH  (DW),
    .LENGTH      (8),
    .HBLANK      (2),
    .FIFO_AW     (3),
    .START_THRESH(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s        (bus),
    .data_out (data_out),
    .out_valid(out_valid),
    .sol      (sol),
    .eol      (eol),
    .underflow(underflow)
`ifdef LINE_TX_UFCNT_EN
    ,
    .uf_count (uf_count)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (out_valid) ok = 1'b1;
  endtask

  // exp = {out_valid, sol, eol, underflow, s_ready, data_out}
  typedef struct {
    logic        rst_n;
    logic        s_valid;
    logic [15:0] s_data;
    logic [20:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic v, input logic [15:0] d,
                              input logic ov, input logic so, input logic eo,
                              input logic uf, input logic rd, input logic [15:0] dd);
    vec_t t;
    t.rst_n   = r;
    t.s_valid = v;
    t.s_data  = d;
    t.exp     = {ov, so, eo, uf, rd, dd};
    return t;
  endfunction

  vec_t vecs[16];

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int nv, cnt, push, ready_bad, ready_low, data_bad, neols, gap, ngaps;
    bit counting;
    int gaps[4];
    logic [15:0] dnext, nxt_exp;
    logic [15:0] bexp[8];

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    rst_n       = 1'b0;

    // Eight pixels back to back, then drain into blanking.
    vecs[0]  = mk(0, 0, 16'h00, 0, 0, 0, 0, 1, 16'h00);
    vecs[1]  = mk(1, 1, 16'h10, 0, 0, 0, 0, 1, 16'h00);
    vecs[2]  = mk(1, 1, 16'h11, 0, 0, 0, 0, 1, 16'h00);
    vecs[3]  = mk(1, 1, 16'h12, 0, 0, 0, 0, 1, 16'h00);
    vecs[4]  = mk(1, 1, 16'h13, 0, 0, 0, 0, 1, 16'h00);
    vecs[5]  = mk(1, 1, 16'h14, 0, 0, 0, 0, 1, 16'h00);
    vecs[6]  = mk(1, 1, 16'h15, 1, 1, 0, 0, 1, 16'h10);
    vecs[7]  = mk(1, 1, 16'h16, 1, 0, 0, 0, 1, 16'h11);
    vecs[8]  = mk(1, 1, 16'h17, 1, 0, 0, 0, 1, 16'h12);
    vecs[9]  = mk(1, 0, 16'h00, 1, 0, 0, 0, 1, 16'h13);
    vecs[10] = mk(1, 0, 16'h00, 1, 0, 0, 0, 1, 16'h14);
    vecs[11] = mk(1, 0, 16'h00, 1, 0, 0, 0, 1, 16'h15);
    vecs[12] = mk(1, 0, 16'h00, 1, 0, 0, 0, 1, 16'h16);
    vecs[13] = mk(1, 0, 16'h00, 1, 0, 1, 0, 1, 16'h17);
    vecs[14] = mk(1, 0, 16'h00, 0, 0, 0, 0, 1, 16'h00);
    vecs[15] = mk(1, 0, 16'h00, 0, 0, 0, 0, 1, 16'h00);

    for (int i = 0; i < 16; i++) begin
      rst_n       = vecs[i].rst_n;
      bus.s_valid = vecs[i].s_valid;
      bus.s_data  = vecs[i].s_data;
      step();
      chk($sformatf("vec%0d", i),
          {11'd0, out_valid, sol, eol, underflow, bus.s_ready, data_out}, {11'd0, vecs[i].exp});
    end

    // Three pixels stay below the start threshold.
    for (int i = 0; i < 3; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 16'h20 + 16'(i);
      step();
    end
    bus.s_valid = 1'b0;
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (out_valid) nv++;
    end
    chk("three_no_start", nv, 0);
    chk("three_ready", bus.s_ready, 1);

    // Fourth pixel starts a line that runs dry after four pixels.
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h23;
    step();
    bus.s_valid = 1'b0;
    wait_valid(20, ok);
    chk("under_start", ok, 1);
    bexp = '{16'h20, 16'h21, 16'h22, 16'h23, 16'h0, 16'h0, 16'h0, 16'h0};
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("under_px%0d", k), {out_valid, sol, eol, underflow, data_out},
          {1'b1, k == 0, k == 7, k >= 4, bexp[k]});
      step();
    end
    chk("under_end_valid", out_valid, 0);
    chk("under_sticky", underflow, 1);
`ifdef LINE_TX_UFCNT_EN
    chk("uf_count", uf_count, 4);
`endif

    // Continuous input across three lines.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_clears_uf", underflow, 0);
    bus.s_valid = 1'b1;
    dnext = 16'h100;
    nxt_exp = 16'h100;
    cnt = 0; ready_bad = 0; ready_low = 0; data_bad = 0;
    neols = 0; gap = 0; ngaps = 0; counting = 1'b0;
    for (int c = 0; c < 100 && neols < 3; c++) begin
      bus.s_data = dnext;
      push = (bus.s_valid && bus.s_ready) ? 1 : 0;
      step();
      if (push != 0) dnext++;
      cnt = cnt + push - (out_valid ? 1 : 0);
      if (bus.s_ready !== (cnt != 8)) ready_bad++;
      if (!bus.s_ready) ready_low++;
      if (out_valid) begin
        if (data_out !== nxt_exp) data_bad++;
        nxt_exp++;
        if (sol && counting && ngaps < 4) begin
          gaps[ngaps] = gap;
          ngaps++;
          counting = 1'b0;
        end
        if (eol) begin
          neols++;
          counting = 1'b1;
          gap = 0;
        end
      end else if (counting) begin
        gap++;
      end
    end
    chk("cont_lines", neols, 3);
    chk("cont_gaps_seen", ngaps, 2);
    chk("cont_gap1", gaps[0], 2);
    chk("cont_gap2", gaps[1], 2);
    chk("cont_data", data_bad, 0);
    chk("cont_ready_vs_occupancy", ready_bad, 0);
    chk("cont_ready_low_seen", ready_low > 0, 1);
    chk("cont_no_underflow", underflow, 0);

    // Reset in the middle of a line.
    rst_n = 1'b0;
    bus.s_valid = 1'b0;
    step();
    rst_n = 1'b1;
    bus.s_valid = 1'b1;
    dnext = 16'h300;
    for (int c = 0; c < 20 && !out_valid; c++) begin
      bus.s_data = dnext;
      dnext++;
      step();
    end
    chk("abort_sol", {out_valid, sol}, 2'b11);
    for (int c = 0; c < 5; c++) begin
      bus.s_data = dnext;
      dnext++;
      step();
    end
    chk("abort_col5", {out_valid, sol, eol, data_out}, {3'b100, 16'h305});
    rst_n = 1'b0;
    bus.s_valid = 1'b0;
    step();
    chk("abort_reset", {out_valid, sol, eol, bus.s_ready, data_out}, {4'b0001, 16'h0});
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 16'h40 + 16'(i);
      step();
    end
    bus.s_valid = 1'b0;
    wait_valid(20, ok);
    chk("restart_start", ok, 1);
    chk("restart_first", {out_valid, sol, eol, data_out}, {3'b110, 16'h40});
    step();
    step();
    step();
    chk("restart_fourth", {out_valid, sol, eol, data_out}, {3'b100, 16'h43});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/line_tx.md
LINE_TX -- requirements
Module: line_tx

Interface
REQ-001 Parameter ADDR_WIDTH, default 11: column counter width.
REQ-002 Parameter DATA_WIDTH, default 16: pixel width.
REQ-003 Parameter LENGTH, default 1920: active pixels per line.
REQ-004 Parameter HBLANK, default 16: idle cycles after each line, >=1.
REQ-005 Parameter FIFO_AW, default 4: FIFO depth 2**FIFO_AW.
REQ-006 Parameter START_THRESH, default 8: FIFO occupancy needed to start a line, 1..2**FIFO_AW.
REQ-007 clk  input  1  clock; all logic on rising edge.
REQ-008 rst_n  input  1  reset; synchronous, active-low.
REQ-009 s_data  input  DATA_WIDTH  upstream pixel.
REQ-010 s_valid  input  1  upstream pixel valid.
REQ-011 s_ready  output  1  FIFO can accept; transfer when s_valid && s_ready.
REQ-012 data_out  output  DATA_WIDTH  pixel to line-buffer data_in.
REQ-013 out_valid  output  1  pixel valid, drives line-buffer in_valid; no backpressure.
REQ-014 sol  output  1  first pixel of line, qualified by out_valid.
REQ-015 eol  output  1  last pixel of line, qualified by out_valid.
REQ-016 underflow  output  1  sticky: a fill pixel was emitted.

Function
REQ-017 FIFO SHALL be synchronous, 2**FIFO_AW x DATA_WIDTH, pointer wrap-around, occupancy count 0..2**FIFO_AW.
REQ-018 s_ready SHALL be combinational: count != 2**FIFO_AW.
REQ-019 FSM states IDLE, ACTIVE, BLANK; reset state IDLE.
REQ-020 IDLE -> ACTIVE when registered count >= START_THRESH; else stay.
REQ-021 ACTIVE: each cycle out_valid=1 next edge; column counter 0..LENGTH-1; ACTIVE -> BLANK after column LENGTH-1.
REQ-022 BLANK: out_valid=0 for exactly HBLANK cycles, then IDLE.
REQ-023 Outputs SHALL be registered; first out_valid one cycle after IDLE->ACTIVE decision; lines exactly LENGTH contiguous valid cycles.
REQ-024 ACTIVE pop: count>0 -> data_out = FIFO head, pop; count==0 -> data_out=0, no pop, underflow set.
REQ-025 Push and pop in same cycle SHALL leave count unchanged; push at count 0 is not visible to same-cycle pop.
REQ-026 sol=1 only at column 0, eol=1 only at column LENGTH-1; both 0 when out_valid=0.
REQ-027 underflow SHALL remain set until reset.

Reset
REQ-028 Under reset: FSM IDLE, pointers/count/column 0, FIFO contents discarded.
REQ-029 Reset values: data_out=0, out_valid=0, sol=0, eol=0, underflow=0, s_ready=1 the cycle after reset.
REQ-030 Reset mid-line SHALL abort line immediately; no eol emitted.

Configuration
REQ-031 Macro LINE_TX_UFCNT_EN defined: extra output uf_count [15:0], increments per fill pixel, saturates at 16'hFFFF, resets to 0.
REQ-032 Macro undefined: no uf_count port or logic; all other behaviour identical.

Verification (LENGTH=8, HBLANK=2, FIFO_AW=3, START_THRESH=4)
REQ-033 Push 0x10..0x17 back-to-back -> out_valid 8 cycles, data 0x10..0x17, sol on 0x10, eol on 0x17, underflow=0.
REQ-034 Push 3 pixels only -> out_valid stays 0 indefinitely.
REQ-035 Push 4 pixels then stop -> 4 data pixels, 4 zero pixels, eol on 8th, underflow=1 (uf_count=4 if enabled).
REQ-036 Continuous s_valid, 2 lines -> exactly 2 idle cycles between eol and next sol; s_ready low while count=8.
REQ-037 rst_n low at column 5 -> next cycle out_valid=0, count=0; new line begins at column 0 with sol.
